// File: rtl/subi_shared_pkg.sv
// subi_shared_pkg: shared width helper and packed-slice offset helper for the shared subtractor
package subi_shared_pkg;
  function automatic int tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
  function automatic int lsb(input int idx, input int w);
    return idx * w;
  endfunction
endpackage

// File: rtl/subi_shared_if.sv
// subi_shared_if: per-requester lhs/rhs/result handshakes of the shared subtractor (master = requesters, slave = unit)
interface subi_shared_if #(
  parameter int DATA_TYPE = 32,
  parameter int NUM_REQ   = 2
);
  logic [NUM_REQ*DATA_TYPE-1:0] lhs, rhs;
  logic [NUM_REQ-1:0]           lhs_valid, lhs_ready, rhs_valid, rhs_ready;
  logic [DATA_TYPE-1:0]         result;
  logic [NUM_REQ-1:0]           result_valid, result_ready;
  modport master (
    output lhs, lhs_valid, rhs, rhs_valid, result_ready,
    input  lhs_ready, rhs_ready, result, result_valid
  );
  modport slave (
    input  lhs, lhs_valid, rhs, rhs_valid, result_ready,
    output lhs_ready, rhs_ready, result, result_valid
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin, req/prio_ptr in, one-hot grant and its index gidx out
module rr_arbiter import subi_shared_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = tag_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [TAG_W-1:0]   prio_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [TAG_W-1:0]   gidx
);
  function automatic int rot(input int p, input int k);
    return (p + k) % NUM_REQ;
  endfunction
  always_comb begin
    grant = '0;
    gidx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[rot(int'(prio_ptr), k)]) begin
        grant = NUM_REQ'(1) << rot(int'(prio_ptr), k);
        gidx  = TAG_W'(rot(int'(prio_ptr), k));
      end
    end
  end
endmodule

// File: rtl/subi_shared_rr.sv
// subi_shared_rr: one subtractor shared round-robin by NUM_REQ requesters via bus, 1-slot tagged result register; clk, async rst
module subi_shared_rr import subi_shared_pkg::*; #(
  parameter int DATA_TYPE = 32,
  parameter int NUM_REQ   = 2
) (
  input logic       clk,
  input logic       rst,
  subi_shared_if.slave bus
);
  localparam int TAG_W = tag_w(NUM_REQ);
  logic [NUM_REQ-1:0]   req, grant;
  logic [TAG_W-1:0]     gidx, prio_ptr, slot_tag, next_ptr;
  logic                 slot_valid, load_en, fire;
  logic [DATA_TYPE-1:0] slot_data, diff;
  assign req = bus.lhs_valid & bus.rhs_valid;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) u_arb (
    .req(req), .prio_ptr(prio_ptr), .grant(grant), .gidx(gidx)
  );
  assign bus.result_valid = slot_valid ? NUM_REQ'(1) << slot_tag : '0;
  assign bus.result       = slot_data;
  // result_valid is one-hot, so this is the drain of the slot's own requester
  assign load_en       = !slot_valid || |(bus.result_valid & bus.result_ready);
  assign fire          = load_en && |req && !rst;
  assign bus.lhs_ready = {NUM_REQ{load_en && !rst}} & grant;
  assign bus.rhs_ready = {NUM_REQ{load_en && !rst}} & grant;
  assign diff     = bus.lhs[lsb(int'(gidx), DATA_TYPE) +: DATA_TYPE] - bus.rhs[lsb(int'(gidx), DATA_TYPE) +: DATA_TYPE];
  assign next_ptr = (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_valid <= 1'b0;
      slot_tag   <= '0;
      slot_data  <= '0;
      prio_ptr   <= '0;
    end else if (fire) begin
      slot_valid <= 1'b1;
      slot_tag   <= gidx;
      slot_data  <= diff;
      prio_ptr   <= next_ptr;
    end else if (load_en) begin
      slot_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_subi_shared_rr.sv
// tb_subi_shared_rr: randomized and directed checks of subi_shared_rr against a behavioural model
module tb_subi_shared_rr;
  localparam int W = 32;
  localparam int N = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  subi_shared_if #(.DATA_TYPE(W), .NUM_REQ(N)) bus ();
  subi_shared_rr #(.DATA_TYPE(W), .NUM_REQ(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic lv, input logic rv);
    bus.lhs[i*W +: W] = a;
    bus.rhs[i*W +: W] = b;
    bus.lhs_valid[i]  = lv;
    bus.rhs_valid[i]  = rv;
  endtask
  task automatic idle();
    bus.lhs_valid = '0;
    bus.rhs_valid = '0;
  endtask
  // Model: the pending result (if any) and the last requester served; the
  // next grant goes to the first eligible requester after the last one served.
  bit          m_valid = 0;
  int          m_tag   = 0;
  logic [W-1:0] m_data = '0;
  int          m_last  = N - 1;
  always @(negedge clk) begin
    int w;
    bit drain;
    logic [N-1:0] exp_rd;
    if (rst) begin
      chk("rst_result_valid", 32'(bus.result_valid), 0);
      chk("rst_lhs_ready", 32'(bus.lhs_ready), 0);
      chk("rst_rhs_ready", 32'(bus.rhs_ready), 0);
      chk("rst_result", bus.result, 0);
      m_valid = 0;
      m_last  = N - 1;
    end else begin
      chk("m_result_valid", 32'(bus.result_valid), m_valid ? 32'(1) << m_tag : 0);
      if (m_valid) chk("m_result", bus.result, m_data);
      drain = m_valid && bus.result_ready[m_tag];
      w = -1;
      for (int k = 1; k <= N; k++)
        if (w < 0 && bus.lhs_valid[(m_last + k) % N] && bus.rhs_valid[(m_last + k) % N]) w = (m_last + k) % N;
      exp_rd = ((!m_valid || drain) && w >= 0) ? N'(1) << w : '0;
      chk("m_lhs_ready", 32'(bus.lhs_ready), 32'(exp_rd));
      chk("m_rhs_ready", 32'(bus.rhs_ready), 32'(exp_rd));
      if ((!m_valid || drain) && w >= 0) begin
        m_valid = 1;
        m_tag   = w;
        m_data  = bus.lhs[w*W +: W] - bus.rhs[w*W +: W];
        m_last  = w;
      end else if (drain) m_valid = 0;
    end
  end
  initial begin
    bus.lhs = '0;
    bus.rhs = '0;
    idle();
    bus.result_ready = '1;
    @(negedge clk);
    chk("reset_rv", 32'(bus.result_valid), 0);
    chk("reset_ready", 32'(bus.lhs_ready | bus.rhs_ready), 0);
    step();
    rst = 1'b0;
    set_req(0, 10, 3, 1, 1);
    @(negedge clk);
    chk("single_lhs_ready", 32'(bus.lhs_ready), 1);
    chk("single_rhs_ready", 32'(bus.rhs_ready), 1);
    step();
    idle();
    @(negedge clk);
    chk("single_result", bus.result, 7);
    chk("single_rv", 32'(bus.result_valid), 1);
    step();
    set_req(0, 0, 1, 1, 1);
    step();
    set_req(0, 32'h8000_0000, 1, 1, 1);
    @(negedge clk);
    chk("wrap_neg1", bus.result, 32'hFFFF_FFFF);
    chk("wrap_rv", 32'(bus.result_valid), 1);
    step();
    idle();
    @(negedge clk);
    chk("wrap_min", bus.result, 32'h7FFF_FFFF);
    step();
    set_req(1, 9, 2, 1, 1);
    bus.result_ready = '0;
    step();
    idle();
    @(negedge clk);
    chk("midrst_hold", bus.result, 7);
    chk("midrst_rv", 32'(bus.result_valid), 2);
    step();
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_rv_in_reset", 32'(bus.result_valid), 0);
    chk("midrst_ready_in_reset", 32'(bus.lhs_ready | bus.rhs_ready), 0);
    step();
    rst = 1'b0;
    bus.result_ready = '1;
    @(negedge clk);
    chk("midrst_no_stale_rv", 32'(bus.result_valid), 0);
    chk("midrst_no_stale_data", bus.result, 0);
    step();
    set_req(0, 5, 2, 1, 1);
    set_req(1, 9, 4, 1, 1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_grant", 32'(bus.lhs_ready), (k % 2 == 0) ? 1 : 2);
      if (k >= 1) begin
        chk("rr_rv", 32'(bus.result_valid), (k % 2 == 1) ? 1 : 2);
        chk("rr_result", bus.result, (k % 2 == 1) ? 3 : 5);
      end
      step();
    end
    bus.result_ready = 2'b10;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_rv", 32'(bus.result_valid), 1);
      chk("bp_result", bus.result, 3);
      chk("bp_ready", 32'(bus.lhs_ready | bus.rhs_ready), 0);
      step();
    end
    bus.result_ready = '1;
    @(negedge clk);
    chk("bp_refill_ready", 32'(bus.lhs_ready), 2);
    chk("bp_refill_rv", 32'(bus.result_valid), 1);
    step();
    @(negedge clk);
    chk("bp_after_rv", 32'(bus.result_valid), 2);
    chk("bp_after_result", bus.result, 5);
    step();
    idle();
    set_req(1, 20, 6, 1, 0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("join_lhs_ready", 32'(bus.lhs_ready), 0);
      step();
    end
    set_req(1, 20, 6, 1, 1);
    @(negedge clk);
    chk("join_fire_ready", 32'(bus.lhs_ready), 2);
    step();
    idle();
    @(negedge clk);
    chk("join_result", bus.result, 14);
    chk("join_rv", 32'(bus.result_valid), 2);
    for (int c = 0; c < 600; c++) begin
      step();
      rst = ($urandom_range(63) == 0);
      for (int i = 0; i < N; i++)
        set_req(i, ($urandom_range(3) == 0) ? W'($urandom_range(3)) : $urandom,
                   ($urandom_range(3) == 0) ? 32'h8000_0000 : $urandom,
                   $urandom_range(3) != 0, $urandom_range(3) != 0);
      bus.result_ready = N'($urandom) | N'($urandom);
    end
    step();
    rst = 1'b0;
    idle();
    bus.result_ready = '1;
    step();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/subi_shared_rr.md
Name: subi_shared_rr

Overview:
- Shares one integer subtractor among NUM_REQ requester channels, each with its own elastic handshake.
- Round-robin arbitration selects one requester whose lhs and rhs are both valid.
- The selected operands are subtracted, and the difference is held in a one-slot output register tagged with the requester index.
- The result is returned on that requester's result channel.
- Used by the resource-sharing pass to replace several low-utilisation subi units in a dataflow circuit.

Parameters:
- DATA_TYPE, 32, operand/result width in bits
- NUM_REQ, 2, number of requester channels (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- lhs  in  NUM_REQ*DATA_TYPE  packed minuends; requester i at [i*DATA_TYPE +: DATA_TYPE]
- lhs_valid  in  NUM_REQ  per-requester lhs valid
- lhs_ready  out  NUM_REQ  per-requester lhs ready
- rhs  in  NUM_REQ*DATA_TYPE  packed subtrahends, same packing as lhs
- rhs_valid  in  NUM_REQ  per-requester rhs valid
- rhs_ready  out  NUM_REQ  per-requester rhs ready
- result  out  DATA_TYPE  shared result bus (slot data)
- result_valid  out  NUM_REQ  one-hot; bit i set when slot holds requester i's result
- result_ready  in  NUM_REQ  per-requester result ready

Behaviour:
- Reset (async, rst=1): slot_valid=0, slot_tag=0, slot_data=0, prio_ptr=0. All *_ready=0, result_valid=0, result=0 while rst is high. An in-flight result is discarded and not replayed.
- Eligibility: req[i] = lhs_valid[i] & rhs_valid[i]. Operands are joined; neither is consumed alone.
- Slot free: load_en = !slot_valid | (result_valid[slot_tag] & result_ready[slot_tag]). A new result can enter in the same cycle the old one drains.
- Arbiter: combinational round-robin over req, searching from prio_ptr upward with wrap. Output is one-hot grant (zero if no req) and index gidx.
- Ready outputs: lhs_ready[i] = rhs_ready[i] = grant[i] & load_en. Ready is never asserted for a non-eligible requester.
- Fire: when load_en & |req at the clock edge:
  - slot_data <= lhs[gidx] - rhs[gidx], modulo 2^DATA_TYPE (wrap, no saturation, no flags);
  - slot_tag <= gidx; slot_valid <= 1;
  - prio_ptr <= (gidx+1) mod NUM_REQ.
- Drain without refill: slot_valid <= 0; prio_ptr unchanged.
- Latency: exactly 1 cycle from fire to result_valid.
- Throughput: 1 result per cycle when the consumer is always ready.
- result = slot_data. result_valid[i] = slot_valid & (slot_tag==i).
- Stability: slot_data/slot_tag hold while result_valid is set and not accepted. Inputs are never consumed while the slot is blocked.
- Fairness: a continuously eligible requester is granted within NUM_REQ fires.
- Combinational paths exist from result_ready to lhs_ready/rhs_ready. There is no path from *_valid to result_valid.
- NUM_REQ=1: grant = req[0], prio_ptr is constant 0, and the block behaves as a registered subtractor with a 1-slot buffer.

Decomposition:
- Shared package, subi_shared_pkg:
  - clog2-based TAG_W = max(1, $clog2(NUM_REQ));
  - helper function for packed-slice extraction.
- One sub-module, rr_arbiter:
  - parameter NUM_REQ;
  - inputs req, prio_ptr;
  - outputs grant (one-hot) and gidx;
  - purely combinational.
- The pointer register stays in subi_shared_rr so the arbiter is reusable by other shared-unit wrappers.

Test Plan:
- Reset mid-result: slot holds 7 for req1, assert rst for 1 cycle -> result_valid=00 and all ready=0 during reset; no stale 7 appears after release.
- Single requester, DATA_TYPE=32, NUM_REQ=2: req0 lhs=10, rhs=3, result_ready=11 -> lhs_ready[0]=rhs_ready[0]=1 that cycle; next cycle result=7, result_valid=01.
- Wrap-around: lhs=0, rhs=1 -> result=0xFFFFFFFF; lhs=0x80000000, rhs=1 -> 0x7FFFFFFF.
- Contention and round-robin: both requesters valid every cycle (req0 5-2, req1 9-4), ptr=0 -> grants alternate 0,1,0,1. Results are 3 (tag0), 5 (tag1), ... at one per cycle.
- Back-pressure: req0 result ready=0 for 3 cycles with result 3 pending -> result and result_valid=01 stable; lhs_ready=rhs_ready=00 for all requesters. Release ready -> drain and refill occur in the same cycle.
- Join: lhs_valid[1]=1, rhs_valid[1]=0 for 4 cycles -> no grant to 1 and lhs_ready[1]=0. Raise rhs_valid[1] -> fire next edge, result=lhs-rhs tagged 1.
